fpu_issue_ctrl: RTL and testbench
=================================

// Module: fpu_issue_ctrl
// PURPOSE
//  Integer-core side of the FPU interface; drives the FPU inst/is_legl/from_intreg/clken inputs.
//  Holds one FP instruction, inserts bubbles while the FPU raises hazard, supplies int rs1 data,
//  and retires FPU results bound for the integer register file (fcmp/fcvt.w.s/fmv.x.w).
//  Sits between decode and the FPU; the integer writeback mux consumes its iwb_* outputs.
// PARAMETERS
//  FTOI_LAT  2  cycles from an accepted issue (fpu_is_legl=1 edge) to fpu_to_intreg valid
//  XLEN      32 integer/float data width
// PORTS
//  clk             in   1     single clock; all state on posedge
//  rstn            in   1     asynchronous, active-low reset
//  in_valid        in   1     decode presents an FP instruction
//  in_ready        out  1     controller can accept (holding register empty or draining this cycle)
//  in_inst         in   32    RV32F instruction word
//  in_rs1_val      in   XLEN  integer rs1 value read by decode
//  flush           in   1     discard held instruction and all pending int writebacks
//  fpu_clken       out  1     FPU clock enable
//  fpu_is_legl     out  1     instruction on fpu_inst is real (0 = bubble)
//  fpu_inst        out  32    instruction word to FPU
//  fpu_from_intreg out  XLEN  integer operand to FPU
//  fpu_hazard      in   1     FPU combinational hazard for fpu_inst
//  fpu_to_intreg   in   XLEN  FPU integer result
//  iwb_valid       out  1     integer writeback strobe
//  iwb_rd          out  5     integer destination
//  iwb_data        out  XLEN  integer writeback data
// BEHAVIOUR
//  - Reset: holding reg empty, in_ready=1, fpu_is_legl=0, fpu_inst=32'h0000_0013, fpu_from_intreg=0,
//    iwb_valid=0, iwb_rd=0, iwb_data=0, pending pipe cleared. fpu_clken=1 out of reset.
//  - States HOLD_EMPTY / HOLD_FULL. EMPTY + in_valid -> capture inst+rs1_val, go FULL.
//  - FULL: issue fires when !fpu_hazard && !int_dep; fpu_is_legl=1 that cycle, reg frees.
//    Same-cycle refill allowed: in_ready = EMPTY | issue. Otherwise fpu_is_legl=0 (bubble), hold.
//  - int_dep: held inst reads int rs1 (fmv.w.x, fcvt.s.w[u]) and rs1 matches a pending int-result rd
//    not yet written back; stall until its iwb cycle has passed (no int->FPU bypass).
//  - Pending pipe: FTOI_LAT-deep shift of {valid,rd}; entry set on issue of funct5 10100/11000/11100
//    with opcode 1010011 and rd!=0. At depth FTOI_LAT: iwb_valid=1, iwb_rd=rd, iwb_data=fpu_to_intreg.
//  - fpu_inst is the held word whenever FULL (FPU hazard evaluates it), else NOP with is_legl=0.
//  - flush: same edge empties holding reg, clears pending pipe; a same-cycle issue is suppressed;
//    in_valid ignored that cycle. Reset mid-operation behaves as flush plus output reset values.
//  - fpu_clken held at 1; reserved for a later global stall input.
// CONFIGURATION
//  FPU_ISSUE_PERF_EN: defined -> adds outputs perf_stall_cnt[31:0] (cycles FULL and not issuing)
//    and perf_issue_cnt[31:0] (issues); both wrap at 2^32, reset to 0, not cleared by flush.
//    Undefined -> ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package fpu_pkg: opcode constants (OP_FP=7'b1010011, LOAD_FP, STORE_FP, FMADD..FNMADD),
//  funct5 constants (FCMP, FCVT_W, FMV_X), NOP word, pending-entry struct {valid, rd}.
//  One sub-module: fpu_int_result_pipe (pending shift register + rs1 dependency compare).
// TESTING
//  1. fadd.s issued with fpu_hazard=0 -> fpu_is_legl=1 next edge, in_ready stays 1, no iwb.
//  2. fpu_hazard=1 for 3 cycles on held fmul -> 3 bubbles (is_legl=0), in_ready=0, issue on cycle 4.
//  3. feq.s rd=x5 issued at T -> iwb_valid=1, iwb_rd=5, iwb_data=fpu_to_intreg at T+2 only.
//  4. fle.s rd=x7 then fmv.w.x rs1=x7 back-to-back -> fmv held until after x7 iwb cycle, then issues.
//  5. flush while FULL with hazard and one pending feq -> no issue, no iwb afterward, in_ready=1.
//  6. rstn low mid-stall -> all outputs to reset values asynchronously; PERF_EN counters read 0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared RV32F encoding constants and types for the integer-core side of the FPU interface.
package fpu_pkg;

    localparam logic [6:0] OP_FP     = 7'b1010011;
    localparam logic [6:0] LOAD_FP   = 7'b0000111;
    localparam logic [6:0] STORE_FP  = 7'b0100111;
    localparam logic [6:0] FMADD     = 7'b1000011;
    localparam logic [6:0] FMSUB     = 7'b1000111;
    localparam logic [6:0] FNMSUB    = 7'b1001011;
    localparam logic [6:0] FNMADD    = 7'b1001111;

    // funct5 values producing an integer result
    localparam logic [4:0] FCMP      = 5'b10100;
    localparam logic [4:0] FCVT_W    = 5'b11000;
    localparam logic [4:0] FMV_X     = 5'b11100;
    // funct5 values consuming integer rs1
    localparam logic [4:0] FCVT_S_W  = 5'b11010;
    localparam logic [4:0] FMV_W_X   = 5'b11110;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic {
        StHoldEmpty,
        StHoldFull
    } hold_state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } pend_entry_t;

    function automatic logic writes_int(input logic [31:0] inst);
        logic [4:0] f5;
        f5 = inst[31:27];
        return (inst[6:0] == OP_FP) && (inst[11:7] != 5'd0) &&
               ((f5 == FCMP) || (f5 == FCVT_W) || (f5 == FMV_X));
    endfunction

    function automatic logic reads_int(input logic [31:0] inst);
        logic [4:0] f5;
        f5 = inst[31:27];
        return (inst[6:0] == OP_FP) && ((f5 == FCVT_S_W) || (f5 == FMV_W_X));
    endfunction

endpackage

// File: rtl/fpu_int_result_pipe.sv
// Tracks FPU results headed for the integer register file and flags rs1 read-after-write hazards.
module fpu_int_result_pipe
    import fpu_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        push,
    input  logic [4:0]  push_rd,
    input  logic [4:0]  rs1,
    output logic        rs1_hit,
    output pend_entry_t head
);

    pend_entry_t [Depth-1:0] pipe_q;
    pend_entry_t             entry_new;

    always_comb begin
        entry_new       = '0;
        entry_new.valid = push;
        entry_new.rd    = push ? push_rd : 5'd0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pipe_q <= '0;
        end else if (flush) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= entry_new;
            for (int i = 1; i < int'(Depth); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Every in-flight entry blocks, including the one writing back this cycle (no bypass).
    always_comb begin
        rs1_hit = 1'b0;
        for (int i = 0; i < int'(Depth); i++) begin
            if (pipe_q[i].valid && (pipe_q[i].rd == rs1)) begin
                rs1_hit = 1'b1;
            end
        end
    end

    assign head = pipe_q[Depth-1];

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Holds one FP instruction, issues it to the FPU around hazards, and retires int-bound results.
// Optional FPU_ISSUE_PERF_EN adds stall/issue performance counters.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned FTOI_LAT = 2,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic            flush,
    output logic            fpu_clken,
    output logic            fpu_is_legl,
    output logic [31:0]     fpu_inst,
    output logic [XLEN-1:0] fpu_from_intreg,
    input  logic            fpu_hazard,
    input  logic [XLEN-1:0] fpu_to_intreg,
    output logic            iwb_valid,
    output logic [4:0]      iwb_rd,
    output logic [XLEN-1:0] iwb_data
`ifdef FPU_ISSUE_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_issue_cnt
`endif
);

    hold_state_e     state_q, state_d;
    logic [31:0]     inst_q;
    logic [XLEN-1:0] rs1_q;
    logic            issue;
    logic            accept;
    logic            int_dep;
    logic            rs1_hit;
    logic            full;
    pend_entry_t     head;

    assign full    = (state_q == StHoldFull);
    assign int_dep = reads_int(inst_q) && rs1_hit;

    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        in_ready = 1'b0;
        accept   = 1'b0;
        unique case (state_q)
            StHoldEmpty: in_ready = 1'b1;
            StHoldFull: begin
                issue    = !fpu_hazard && !int_dep && !flush;
                in_ready = issue;
            end
            default: in_ready = 1'b0;
        endcase
        accept = in_valid && in_ready && !flush;
        if (flush) begin
            state_d = StHoldEmpty;
        end else if (accept) begin
            state_d = StHoldFull;
        end else if (issue) begin
            state_d = StHoldEmpty;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StHoldEmpty;
            inst_q  <= NOP_WORD;
            rs1_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                inst_q <= in_inst;
                rs1_q  <= in_rs1_val;
            end
        end
    end

    fpu_int_result_pipe #(
        .Depth (FTOI_LAT)
    ) u_int_result_pipe (
        .clk     (clk),
        .rstn    (rstn),
        .flush   (flush),
        .push    (issue && writes_int(inst_q)),
        .push_rd (inst_q[11:7]),
        .rs1     (inst_q[19:15]),
        .rs1_hit (rs1_hit),
        .head    (head)
    );

    // FPU sees the held word even while stalled so it can evaluate its hazard on it.
    assign fpu_clken       = 1'b1;
    assign fpu_is_legl     = issue;
    assign fpu_inst        = full ? inst_q : NOP_WORD;
    assign fpu_from_intreg = full ? rs1_q : '0;

    assign iwb_valid = head.valid;
    assign iwb_rd    = head.rd;
    assign iwb_data  = head.valid ? fpu_to_intreg : '0;

`ifdef FPU_ISSUE_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_stall_cnt <= '0;
            perf_issue_cnt <= '0;
        end else begin
            if (full && !issue) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (issue)          perf_issue_cnt <= perf_issue_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed self-checking bench for fpu_issue_ctrl.
module tb_fpu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_rs1_val;
    logic        flush;
    logic        fpu_clken;
    logic        fpu_is_legl;
    logic [31:0] fpu_inst;
    logic [31:0] fpu_from_intreg;
    logic        fpu_hazard;
    logic [31:0] fpu_to_intreg;
    logic        iwb_valid;
    logic [4:0]  iwb_rd;
    logic [31:0] iwb_data;
`ifdef FPU_ISSUE_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_issue_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fpu_issue_ctrl #(
        .FTOI_LAT (2),
        .XLEN     (32)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_inst         (in_inst),
        .in_rs1_val      (in_rs1_val),
        .flush           (flush),
        .fpu_clken       (fpu_clken),
        .fpu_is_legl     (fpu_is_legl),
        .fpu_inst        (fpu_inst),
        .fpu_from_intreg (fpu_from_intreg),
        .fpu_hazard      (fpu_hazard),
        .fpu_to_intreg   (fpu_to_intreg),
        .iwb_valid       (iwb_valid),
        .iwb_rd          (iwb_rd),
        .iwb_data        (iwb_data)
`ifdef FPU_ISSUE_PERF_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_issue_cnt  (perf_issue_cnt)
`endif
    );

    function automatic logic [31:0] fp_op(input logic [4:0] f5, input logic [2:0] rm,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {f5, 2'b00, rs2, rs1, rm, rd, 7'b1010011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 2 time units after the edge, checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] i_fadd, i_fmul, i_feq5, i_fle7, i_fmvwx7;

    initial begin
        i_fadd   = fp_op(5'b00000, 3'b000, 5'd1, 5'd2, 5'd3);
        i_fmul   = fp_op(5'b00010, 3'b000, 5'd4, 5'd5, 5'd6);
        i_feq5   = fp_op(5'b10100, 3'b010, 5'd5, 5'd1, 5'd2);
        i_fle7   = fp_op(5'b10100, 3'b000, 5'd7, 5'd3, 5'd4);
        i_fmvwx7 = fp_op(5'b11110, 3'b000, 5'd8, 5'd7, 5'd0);

        rstn = 1'b0; in_valid = 1'b0; in_inst = '0; in_rs1_val = '0;
        flush = 1'b0; fpu_hazard = 1'b0; fpu_to_intreg = 32'hDEAD_BEEF;
        tick(); #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_is_legl", fpu_is_legl, 0);
        chk("rst_fpu_inst", fpu_inst, NOP);
        chk("rst_from_intreg", fpu_from_intreg, 0);
        chk("rst_iwb_valid", iwb_valid, 0);
        chk("rst_iwb_rd", iwb_rd, 0);
        chk("rst_iwb_data", iwb_data, 0);
        chk("rst_clken", fpu_clken, 1);
        tick(); rstn = 1'b1; tick();

        // fadd issues in the first FULL cycle
        in_valid = 1'b1; in_inst = i_fadd; in_rs1_val = 32'h11; #1;
        chk("t1_in_ready_empty", in_ready, 1);
        tick(); in_valid = 1'b0; #1;
        chk("t1_is_legl", fpu_is_legl, 1);
        chk("t1_fpu_inst", fpu_inst, i_fadd);
        chk("t1_from_intreg", fpu_from_intreg, 32'h11);
        chk("t1_in_ready", in_ready, 1);
        tick(); #1;
        chk("t1_after_is_legl", fpu_is_legl, 0);
        chk("t1_after_inst", fpu_inst, NOP);
        tick(); #1;
        chk("t1_no_iwb", iwb_valid, 0);

        // three hazard bubbles then issue
        in_valid = 1'b1; in_inst = i_fmul; fpu_hazard = 1'b1;
        tick(); in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t2_bubble_legl", fpu_is_legl, 0);
            chk("t2_bubble_ready", in_ready, 0);
            chk("t2_bubble_inst", fpu_inst, i_fmul);
            tick();
        end
        fpu_hazard = 1'b0; #1;
        chk("t2_issue_legl", fpu_is_legl, 1);
        chk("t2_issue_ready", in_ready, 1);
        tick();

        // feq rd=x5 writes back exactly two cycles after issue
        in_valid = 1'b1; in_inst = i_feq5;
        tick(); in_valid = 1'b0; #1;
        chk("t3_issue", fpu_is_legl, 1);
        chk("t3_iwb_T", iwb_valid, 0);
        tick(); #1;
        chk("t3_iwb_T1", iwb_valid, 0);
        tick(); fpu_to_intreg = 32'h1; #1;
        chk("t3_iwb_T2", iwb_valid, 1);
        chk("t3_iwb_rd", iwb_rd, 5);
        chk("t3_iwb_data", iwb_data, 1);
        tick(); #1;
        chk("t3_iwb_T3", iwb_valid, 0);

        // fle rd=x7 then dependent fmv.w.x rs1=x7
        in_valid = 1'b1; in_inst = i_fle7;
        tick(); in_inst = i_fmvwx7; in_rs1_val = 32'h77; #1;
        chk("t4_fle_issue", fpu_is_legl, 1);
        chk("t4_refill_ready", in_ready, 1);
        tick(); in_valid = 1'b0; #1;
        chk("t4_dep_stall1", fpu_is_legl, 0);
        chk("t4_dep_ready", in_ready, 0);
        tick(); fpu_to_intreg = 32'h0; #1;
        chk("t4_fle_iwb", iwb_valid, 1);
        chk("t4_fle_rd", iwb_rd, 7);
        chk("t4_dep_stall2", fpu_is_legl, 0);
        tick(); #1;
        chk("t4_fmv_issue", fpu_is_legl, 1);
        chk("t4_fmv_inst", fpu_inst, i_fmvwx7);
        chk("t4_fmv_rs1", fpu_from_intreg, 32'h77);
        tick(); #1;
        chk("t4_fmv_no_iwb", iwb_valid, 0);

        // flush with a pending feq and a held fmul
        in_valid = 1'b1; in_inst = i_feq5;
        tick(); in_inst = i_fmul; #1;
        chk("t5_feq_issue", fpu_is_legl, 1);
        tick(); flush = 1'b1; in_inst = i_fadd; #1;
        chk("t5_flush_no_issue", fpu_is_legl, 0);
        tick(); flush = 1'b0; in_valid = 1'b0; #1;
        chk("t5_ready", in_ready, 1);
        chk("t5_empty_inst", fpu_inst, NOP);
        chk("t5_no_iwb", iwb_valid, 0);
        tick(); #1;
        chk("t5_no_iwb_later", iwb_valid, 0);

        // asynchronous reset mid-stall with a pending int result
        in_valid = 1'b1; in_inst = i_feq5;
        tick(); in_inst = i_fmul; in_rs1_val = 32'h5A;
        tick(); in_valid = 1'b0; fpu_hazard = 1'b1; #1;
        chk("t6_stalled", in_ready, 0);
        rstn = 1'b0; #1;
        chk("t6_rst_ready", in_ready, 1);
        chk("t6_rst_legl", fpu_is_legl, 0);
        chk("t6_rst_inst", fpu_inst, NOP);
        chk("t6_rst_from_int", fpu_from_intreg, 0);
        chk("t6_rst_iwb", iwb_valid, 0);
`ifdef FPU_ISSUE_PERF_EN
        chk("t6_perf_stall", perf_stall_cnt, 0);
        chk("t6_perf_issue", perf_issue_cnt, 0);
`endif
        tick(); rstn = 1'b1; fpu_hazard = 1'b0;
        tick(); #1;
        chk("t6_post_iwb", iwb_valid, 0);
        chk("t6_post_ready", in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
